// File: rtl/itch_parser_wide_if.sv
// Stream-in / record-out bundle for itch_parser_wide.
// The parser sits on the slave modport. The producer/consumer side uses the master modport.
interface itch_parser_wide_if #(
  parameter int BYTES_PER_BEAT = 4
);
  logic [8*BYTES_PER_BEAT-1:0] data_i;
  logic                        valid_i;
  logic                        ready_o;
  logic [31:0]                 stock_id_o;
  logic [31:0]                 order_ref_num_o;
  logic [31:0]                 num_shares_o;
  logic [31:0]                 price_o;
  logic [3:0]                  order_type_o;
  logic                        buy_sell_o;
  logic                        valid_o;
  logic                        ready_i;

  modport slave (
    input  data_i, valid_i, ready_i,
    output ready_o, stock_id_o, order_ref_num_o, num_shares_o, price_o,
           order_type_o, buy_sell_o, valid_o
  );

  modport master (
    output data_i, valid_i, ready_i,
    input  ready_o, stock_id_o, order_ref_num_o, num_shares_o, price_o,
           order_type_o, buy_sell_o, valid_o
  );
endinterface

// File: rtl/itch_parser_wide.sv
// Wide ITCH 5.0 frame parser: BYTES_PER_BEAT bytes per beat in, decoded A/F/D/E/X order
// records out through a small FIFO.
// Optional feature macro ITCH_STATS_EN adds saturating msg/drop counters.
module itch_parser_wide #(
  parameter int BYTES_PER_BEAT = 4,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic              clk,
  input  logic              reset,
`ifdef ITCH_STATS_EN
  output logic [15:0]       msg_cnt_o,
  output logic [15:0]       drop_cnt_o,
`endif
  itch_parser_wide_if.slave bus
);
  localparam int BPB = BYTES_PER_BEAT;
  localparam int AW  = $clog2(FIFO_DEPTH);

  typedef enum logic {HDR, BODY} state_t;
  typedef struct packed {
    logic [31:0] stock;
    logic [31:0] oref;
    logic [31:0] shares;
    logic [31:0] price;
    logic [3:0]  otype;
    logic        bs;
  } rec_t;

  state_t      state, state_n;
  logic        reset_q, rdy, fire, last, keep, known, push, pop, valid;
  logic [15:0] byte_cnt, base, len_q, len_n, min_len;
  logic [7:0]  type_q, type_n, side_q, side_n;
  logic [31:0] ref_q, ref_n, shaf_q, shaf_n, shex_q, shex_n, stk_q, stk_n, px_q, px_n;
  logic [7:0]  lane [BPB];
  logic [16:0] lidx [BPB];
  logic [16:0] lim;
  rec_t        rec, head;
  rec_t        mem [FIFO_DEPTH];
  logic [AW:0] wp, rp, count;

  // Drop byte b into a big-endian 32-bit field starting at frame offset off.
  function automatic logic [31:0] put32(input logic [31:0] cur, input logic [16:0] idx,
                                        input logic [16:0] off, input logic [7:0] b);
    logic [31:0] f;
    f = cur;
    if (idx >= off && idx <= off + 17'd3) begin
      case (2'(idx - off))
        2'd0: f[31:24] = b;
        2'd1: f[23:16] = b;
        2'd2: f[15:8]  = b;
        default: f[7:0] = b;
      endcase
    end
    return f;
  endfunction

  // Lane 0 lives in the data MSBs; each lane knows its absolute byte index in the frame.
  always_comb begin
    base = (state == BODY) ? byte_cnt : 16'd0;
    for (int l = 0; l < BPB; l++) begin
      lane[l] = bus.data_i[8*(BPB-1-l) +: 8];
      lidx[l] = {1'b0, base} + 17'(l);
    end
  end

  // Merge this beat's bytes into the field shadows; length must be merged first
  // so the end-of-frame and padding cut use this beat's header bytes.
  always_comb begin
    len_n  = len_q;
    type_n = type_q;
    side_n = side_q;
    ref_n  = ref_q;
    shaf_n = shaf_q;
    shex_n = shex_q;
    stk_n  = stk_q;
    px_n   = px_q;
    for (int l = 0; l < BPB; l++) begin
      if (lidx[l] == 17'd0) len_n[15:8] = lane[l];
      if (lidx[l] == 17'd1) len_n[7:0]  = lane[l];
      if (lidx[l] == 17'd2) type_n      = lane[l];
    end
    lim = {1'b0, len_n} + 17'd1;
    for (int l = 0; l < BPB; l++) begin
      if (lidx[l] <= lim) begin
        ref_n  = put32(ref_n,  lidx[l], 17'd15, lane[l]);
        shex_n = put32(shex_n, lidx[l], 17'd19, lane[l]);
        shaf_n = put32(shaf_n, lidx[l], 17'd20, lane[l]);
        stk_n  = put32(stk_n,  lidx[l], 17'd24, lane[l]);
        px_n   = put32(px_n,   lidx[l], 17'd32, lane[l]);
        if (lidx[l] == 17'd19) side_n = lane[l];
      end
    end
    last = ({1'b0, base} + 17'(BPB - 1)) >= lim;
  end

  // Type decode: minimum body length and record assembly with unused fields zeroed.
  always_comb begin
    known   = 1'b1;
    min_len = 16'd0;
    rec     = '0;
    rec.oref = ref_n;
    case (type_n)
      8'h41, 8'h46: begin
        min_len    = (type_n == 8'h41) ? 16'd34 : 16'd38;
        rec.otype  = 4'd1;
        rec.bs     = (side_n == 8'h53);
        rec.shares = shaf_n;
        rec.stock  = stk_n;
        rec.price  = px_n;
      end
      8'h45: begin min_len = 16'd29; rec.otype = 4'd2; rec.shares = shex_n; end
      8'h58: begin min_len = 16'd21; rec.otype = 4'd4; rec.shares = shex_n; end
      8'h44: begin min_len = 16'd17; rec.otype = 4'd8; end
      default: known = 1'b0;
    endcase
    keep = known && (len_n >= min_len);
  end

  assign count = wp - rp;
  assign valid = (count != '0);
  assign rdy   = !reset_q && (count < (AW+1)'(FIFO_DEPTH));
  assign fire  = bus.valid_i && rdy;
  assign push  = fire && last && keep;
  assign pop   = valid && bus.ready_i;

  // Next state: leave HDR only when the frame spills past the first beat.
  always_comb begin
    state_n = state;
    if (fire) state_n = last ? HDR : BODY;
  end

  // Frame state, byte counter and field shadows advance on accepted beats only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reset_q  <= 1'b1;
      state    <= HDR;
      byte_cnt <= '0;
      len_q    <= '0;
      type_q   <= '0;
      side_q   <= '0;
      ref_q    <= '0;
      shaf_q   <= '0;
      shex_q   <= '0;
      stk_q    <= '0;
      px_q     <= '0;
    end else begin
      reset_q <= 1'b0;
      state   <= state_n;
      if (fire) begin
        byte_cnt <= last ? 16'd0 : base + 16'(BPB);
        len_q    <= len_n;
        type_q   <= type_n;
        side_q   <= side_n;
        ref_q    <= ref_n;
        shaf_q   <= shaf_n;
        shex_q   <= shex_n;
        stk_q    <= stk_n;
        px_q     <= px_n;
      end
    end
  end

  // FIFO pointers; extra MSB distinguishes full from empty.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
    end
  end

  // FIFO storage; contents are only visible through the valid-gated head.
  always_ff @(posedge clk) begin
    if (push) mem[wp[AW-1:0]] <= rec;
  end

  assign head                = valid ? mem[rp[AW-1:0]] : '0;
  assign bus.ready_o         = rdy;
  assign bus.valid_o         = valid;
  assign bus.stock_id_o      = head.stock;
  assign bus.order_ref_num_o = head.oref;
  assign bus.num_shares_o    = head.shares;
  assign bus.price_o         = head.price;
  assign bus.order_type_o    = head.otype;
  assign bus.buy_sell_o      = head.bs;

`ifdef ITCH_STATS_EN
  // Saturating counts of records pushed and frames dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      msg_cnt_o  <= '0;
      drop_cnt_o <= '0;
    end else begin
      if (push && msg_cnt_o != 16'hFFFF) msg_cnt_o <= msg_cnt_o + 16'd1;
      if (fire && last && !keep && drop_cnt_o != 16'hFFFF) drop_cnt_o <= drop_cnt_o + 16'd1;
    end
  end
`else
  // Statistics disabled: no counters and no extra ports.
`endif
endmodule

// File: tb/tb_itch_parser_wide.sv
// Directed bench for itch_parser_wide: one BPB=1 instance and one BPB=4 / depth-2 instance.
module tb_itch_parser_wide;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] stk, oref, sh, px;
    logic [3:0]  ty;
    logic        bs;
  } rec_t;

  int n_chk = 0;
  int n_err = 0;
  logic [7:0] frm[$];
  rec_t q1[$];
  rec_t q4[$];

  itch_parser_wide_if #(.BYTES_PER_BEAT(1)) b1();
  itch_parser_wide_if #(.BYTES_PER_BEAT(4)) b4();
`ifdef ITCH_STATS_EN
  logic [15:0] mc1, dc1, mc4, dc4;
`endif

  itch_parser_wide #(.BYTES_PER_BEAT(1), .FIFO_DEPTH(4)) u1 (
    .clk(clk), .reset(rst),
`ifdef ITCH_STATS_EN
    .msg_cnt_o(mc1), .drop_cnt_o(dc1),
`endif
    .bus(b1)
  );

  itch_parser_wide #(.BYTES_PER_BEAT(4), .FIFO_DEPTH(2)) u4 (
    .clk(clk), .reset(rst),
`ifdef ITCH_STATS_EN
    .msg_cnt_o(mc4), .drop_cnt_o(dc4),
`endif
    .bus(b4)
  );

  // Pops happen at the next rising edge; capture the head half a cycle early.
  always @(negedge clk) begin
    if (b1.valid_o && b1.ready_i)
      q1.push_back('{b1.stock_id_o, b1.order_ref_num_o, b1.num_shares_o, b1.price_o,
                     b1.order_type_o, b1.buy_sell_o});
    if (b4.valid_o && b4.ready_i)
      q4.push_back('{b4.stock_id_o, b4.order_ref_num_o, b4.num_shares_o, b4.price_o,
                     b4.order_type_o, b4.buy_sell_o});
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, obs, exp);
    end
  endtask

  task automatic chk_rec(input string tag, input rec_t r, input logic [31:0] stk,
                         input logic [31:0] oref, input logic [31:0] sh,
                         input logic [31:0] px, input logic [3:0] ty, input logic bs);
    chk({tag, ".stk"}, r.stk, stk);
    chk({tag, ".ref"}, r.oref, oref);
    chk({tag, ".sh"}, r.sh, sh);
    chk({tag, ".px"}, r.px, px);
    chk({tag, ".ty"}, r.ty, ty);
    chk({tag, ".bs"}, r.bs, bs);
  endtask

  // Frame of body length len with nonzero filler, so unused fields must be zeroed by the DUT.
  task automatic mk(input int len, input logic [7:0] ty);
    frm.delete();
    frm.push_back(8'(len >> 8));
    frm.push_back(8'(len));
    for (int i = 0; i < len; i++) frm.push_back(8'(8'h10 + i));
    frm[2] = ty;
  endtask

  task automatic p32(input int off, input logic [31:0] v);
    for (int k = 0; k < 4; k++) frm[off+k] = v[8*(3-k) +: 8];
  endtask

  // Send beats [b0, b1) of frm (b1 < 0 means to the end); called just after a rising edge.
  task automatic send(input int w, input int b0, input int b1e);
    int bpb, nb, t;
    bpb = (w == 1) ? 1 : 4;
    nb  = (frm.size() + bpb - 1) / bpb;
    if (b1e >= 0 && b1e < nb) nb = b1e;
    for (int b = b0; b < nb; b++) begin
      if (w == 1) begin
        b1.data_i  = frm[b];
        b1.valid_i = 1'b1;
      end else begin
        for (int l = 0; l < 4; l++)
          b4.data_i[8*(3-l) +: 8] = (b*4 + l < frm.size()) ? frm[b*4+l] : 8'hEE;
        b4.valid_i = 1'b1;
      end
      t = 0;
      @(negedge clk);
      while (!((w == 1) ? b1.ready_o : b4.ready_o) && t < 300) begin
        t++;
        @(negedge clk);
      end
      if (t >= 300) chk("ready_timeout", 0, 1);
      @(posedge clk); #1;
    end
    b1.valid_i = 1'b0;
    b4.valid_i = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    q1.delete();
    q4.delete();
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic settle();
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    b1.data_i = '0; b1.valid_i = 1'b0; b1.ready_i = 1'b1;
    b4.data_i = '0; b4.valid_i = 1'b0; b4.ready_i = 1'b0;
    #7;
    // reset state
    chk("rst_rdy4", b4.ready_o, 0);
    chk("rst_vld4", b4.valid_o, 0);
    chk("rst_ref4", b4.order_ref_num_o, 0);
    chk("rst_rdy1", b1.ready_o, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rdy_after_rst", b4.ready_o, 1);

    // 1: BPB=1 add order
    mk(36, 8'h41); p32(15, 32'h0000232D); frm[19] = 8'h53; p32(20, 600);
    p32(24, 32'h41524758); p32(32, 32'h00105DD8);
    send(1, 0, -1); settle();
    chk("t1_cnt", q1.size(), 1);
    if (q1.size() > 0) chk_rec("t1", q1[0], 32'h41524758, 32'h232D, 600, 32'h00105DD8, 1, 1);

    // 2: delete, six beats, latency
    b4.ready_i = 1'b0;
    mk(19, 8'h44); p32(15, 32'h000003A8); frm[19] = 8'h53;
    send(4, 0, 5);
    chk("t2_vld_pre", b4.valid_o, 0);
    send(4, 5, -1);
    chk("t2_vld_lat", b4.valid_o, 1);
    chk_rec("t2", '{b4.stock_id_o, b4.order_ref_num_o, b4.num_shares_o, b4.price_o,
                    b4.order_type_o, b4.buy_sell_o}, 0, 936, 0, 0, 8, 0);
    b4.ready_i = 1'b1;
    @(posedge clk); #1;
    chk("t2_popped", b4.valid_o, 0);

    // 3: unknown type then F
    do_reset();
    mk(16, 8'h00); send(4, 0, -1);
    mk(38, 8'h46); p32(15, 32'h77); frm[19] = 8'h42; p32(20, 100);
    p32(24, 32'h5A565A5A); p32(32, 32'h00015F90);
    send(4, 0, -1); settle();
    chk("t3_cnt", q4.size(), 1);
    if (q4.size() > 0) chk_rec("t3", q4[0], 32'h5A565A5A, 32'h77, 100, 32'h15F90, 1, 0);
`ifdef ITCH_STATS_EN
    chk("t3_drop", dc4, 1);
    chk("t3_msg", mc4, 1);
`endif

    // 4: backpressure, depth 2
    do_reset();
    b4.ready_i = 1'b0;
    for (int r = 1; r <= 2; r++) begin
      mk(34, 8'h41); p32(15, r); frm[19] = 8'h53; p32(20, r*10); p32(24, 32'h41424344);
      p32(32, 32'h1000 + r);
      send(4, 0, -1);
    end
    chk("t4_full_rdy", b4.ready_o, 0);
    mk(34, 8'h41); p32(15, 3); frm[19] = 8'h42; p32(20, 30); p32(24, 32'h41424344);
    p32(32, 32'h1003);
    fork
      send(4, 0, -1);
      begin
        repeat (3) @(posedge clk);
        #1;
        chk("t4_stall_rdy", b4.ready_o, 0);
        b4.ready_i = 1'b1;
      end
    join
    settle();
    chk("t4_cnt", q4.size(), 3);
    for (int r = 0; r < 3 && r < q4.size(); r++) chk("t4_order", q4[r].oref, r + 1);
    if (q4.size() > 2) chk_rec("t4_3rd", q4[2], 32'h41424344, 3, 30, 32'h1003, 1, 0);

    // 5: E then short A
    do_reset();
    mk(31, 8'h45); p32(15, 32'h1234); p32(19, 32'h64); send(4, 0, -1);
    mk(32, 8'h41); p32(15, 32'h9999); send(4, 0, -1);
    settle();
    chk("t5_cnt", q4.size(), 1);
    if (q4.size() > 0) chk_rec("t5", q4[0], 0, 32'h1234, 100, 0, 2, 0);
`ifdef ITCH_STATS_EN
    chk("t5_drop", dc4, 1);
    chk("t5_msg", mc4, 1);
`endif

    // 6: reset mid-frame with a record pending
    do_reset();
    b4.ready_i = 1'b0;
    mk(19, 8'h44); p32(15, 32'h55); send(4, 0, -1);
    chk("t6_pend", b4.valid_o, 1);
    mk(34, 8'h41); p32(15, 32'hDEAD); send(4, 0, 5);
    rst = 1'b1;
    #1;
    chk("t6_rst_vld", b4.valid_o, 0);
    chk("t6_rst_rdy", b4.ready_o, 0);
    @(posedge clk); #1;
    chk("t6_rst_rdy2", b4.ready_o, 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    q4.delete();
    b4.ready_i = 1'b1;
    mk(34, 8'h41); p32(15, 32'hABCD); frm[19] = 8'h42; p32(20, 5);
    p32(24, 32'h51525354); p32(32, 32'h00002710);
    send(4, 0, -1); settle();
    chk("t6_cnt", q4.size(), 1);
    if (q4.size() > 0) chk_rec("t6", q4[0], 32'h51525354, 32'hABCD, 5, 32'h2710, 1, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
